// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encodings and widths for the accumulator unit
package acc_pkg;

    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/acc_unit_sat_add.sv
// rtl/acc_unit_sat_add.sv - combinational saturating add of a signed product into the accumulator
module sat_add
    import acc_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] operand,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     sat_event
);

    localparam logic signed [ACC_W-1:0] MAX_VAL = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] acc_ext;
    logic signed [ACC_W:0] opd_ext;
    logic signed [ACC_W:0] wide;

    assign acc_ext = {acc[ACC_W-1], acc};
    assign opd_ext = {{(ACC_W+1-PROD_W){operand[PROD_W-1]}}, operand};
    assign wide    = acc_ext + opd_ext;

    // The two top bits of the extended sum disagree exactly when the result left ACC_W range.
    always_comb begin
        sum       = wide[ACC_W-1:0];
        sat_event = 1'b0;
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sat_event = 1'b1;
            sum       = wide[ACC_W] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/acc_unit.sv
// rtl/acc_unit.sv - sums N_TERMS signed multiplier products with saturation and a result handshake
module acc_unit
    import acc_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] product,
    input  logic                     product_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     acc_ovf,
    output logic                     busy
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         count;
    logic signed [ACC_W-1:0]  acc;
    logic                     ovf;
    logic                     beat;
    logic signed [ACC_W-1:0]  sum;
    logic                     sat_event;

    sat_add #(
        .ACC_W(ACC_W)
    ) u_sat_add (
        .acc      (acc),
        .operand  (product),
        .sum      (sum),
        .sat_event(sat_event)
    );

    assign beat    = in_valid && (state == ACCUM);
    assign acc_out = acc;
    assign acc_ovf = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs decode straight from the state so reset clears them without a clock.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (count == LAST_CNT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result registers are only cleared by start, so a consumed result stays readable in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if ((state == IDLE) && start) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (beat) begin
            acc   <= sum;
            count <= count + 1'b1;
            ovf   <= ovf | product_ovf | sat_event;
        end
    end

endmodule

// File: tb/tb_acc_unit.sv
// tb/tb_acc_unit.sv - scoreboard bench for acc_unit with directed product vectors
module tb_acc_unit;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] product = '0;
    logic               product_ovf = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [31:0] acc_out;
    logic               acc_ovf;
    logic               busy;

    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;
    exp_t sb[$];

    acc_unit #(.N_TERMS(4), .ACC_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .product    (product),
        .product_ovf(product_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_out    (acc_out),
        .acc_ovf    (acc_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", acc_out);
            end else begin
                e = sb.pop_front();
                popped++;
                chk("result_acc", acc_out, e.acc);
                chk("result_ovf", {31'd0, acc_ovf}, {31'd0, e.ovf});
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic o);
        exp_t e;
        e.acc = a;
        e.ovf = o;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] v, input logic o);
        in_valid    = 1'b1;
        product     = v;
        product_ovf = o;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        product_ovf = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1", name);
        end
    endtask

    task automatic drain(input string name);
        wait_valid(name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic [6:0] pat;

    initial begin
        #2;
        chk("rst_acc", acc_out, 32'd0);
        chk("rst_ovf", {31'd0, acc_ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 100 - 50 + 7 + 3 = 60, result one cycle after the fourth beat
        do_start();
        chk("a_in_ready", {31'd0, in_ready}, 32'd1);
        chk("a_busy", {31'd0, busy}, 32'd1);
        push_exp(32'd60, 1'b0);
        beat(32'd100, 1'b0);
        beat(-32'sd50, 1'b0);
        chk("a_partial", acc_out, 32'd50);
        beat(32'd7, 1'b0);
        chk("a_pre_valid", {31'd0, out_valid}, 32'd0);
        beat(32'd3, 1'b0);
        chk("a_latency", {31'd0, out_valid}, 32'd1);
        chk("a_done_in_ready", {31'd0, in_ready}, 32'd0);
        drain("a");

        do_start();
        push_exp(32'h7FFF_FFFF, 1'b1);
        beat(32'h7FFF_0000, 1'b0);
        beat(32'h7FFF_0000, 1'b0);
        beat(32'd0, 1'b0);
        beat(32'd0, 1'b0);
        drain("sat_pos");

        do_start();
        chk("start_clears_acc", acc_out, 32'd0);
        chk("start_clears_ovf", {31'd0, acc_ovf}, 32'd0);
        push_exp(32'h8000_0000, 1'b1);
        beat(32'h8001_0000, 1'b0);
        beat(32'h8001_0000, 1'b0);
        beat(32'd0, 1'b0);
        beat(32'd0, 1'b0);
        drain("sat_neg");

        do_start();
        push_exp(32'd10, 1'b1);
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b1);
        beat(32'd3, 1'b0);
        beat(32'd4, 1'b0);
        drain("povf");

        // Gap cycles carry a poison product that must not be summed
        do_start();
        push_exp(32'd20, 1'b0);
        pat = 7'b1101001;
        for (int i = 0; i < 7; i++) begin
            in_valid    = pat[i];
            product     = pat[i] ? 32'd5 : 32'd999;
            product_ovf = ~pat[i];
            @(posedge clk); #1;
        end
        in_valid    = 1'b0;
        product_ovf = 1'b0;
        drain("gaps");

        do_start();
        push_exp(32'd100, 1'b0);
        beat(32'd10, 1'b0);
        beat(32'd20, 1'b0);
        beat(32'd30, 1'b0);
        beat(32'd40, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_acc", acc_out, 32'd100);
            chk("stall_ovf", {31'd0, acc_ovf}, 32'd0);
        end
        start = 1'b0;
        drain("stall");
        chk("retain_acc", acc_out, 32'd100);

        do_start();
        beat(32'd9, 1'b0);
        beat(32'd9, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_acc", acc_out, 32'd0);
        chk("async_ovf", {31'd0, acc_ovf}, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd0);
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        end
        do_start();
        push_exp(32'd4, 1'b0);
        for (int i = 0; i < 4; i++) beat(32'd1, 1'b0);
        drain("after_rst");

        @(posedge clk); #1;
        chk("sb_empty", sb.size(), 32'd0);
        chk("sb_count", popped, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_unit.md
ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 Parameter N_TERMS, default 4, number of products summed per accumulation (legal range 1..255).
REQ-002 Parameter ACC_W, default 32, signed accumulator width (ACC_W >= 32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-006 in_valid  input  1  upstream multiplier product is valid.
REQ-007 in_ready  output  1  block accepts a product this cycle.
REQ-008 product  input  32  signed product from the upstream 16x16 multiplier.
REQ-009 product_ovf  input  1  multiplier overflow flag, qualified by in_valid.
REQ-010 out_valid  output  1  accumulated result is available.
REQ-011 out_ready  input  1  downstream consumes the result.
REQ-012 acc_out  output  ACC_W  signed accumulated sum, registered.
REQ-013 acc_ovf  output  1  sticky flag: any accepted product_ovf or any saturation event in the current accumulation.
REQ-014 busy  output  1  high in ACCUM and DONE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM, DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; on start=1, clear acc, beat count and acc_ovf, then go to ACCUM next cycle.
REQ-017 ACCUM: in_ready=1; a beat is accepted when in_valid && in_ready; cycles with in_valid=0 SHALL change nothing.
REQ-018 On an accepted beat: acc <= sat(acc + sign_extend(product)); count <= count+1; acc_ovf <= acc_ovf | product_ovf | sat_event.
REQ-019 Addition SHALL be performed at ACC_W+1 bits; result > 2^(ACC_W-1)-1 clamps to that value, result < -2^(ACC_W-1) clamps to that value; either clamp sets sat_event.
REQ-020 The beat that makes count equal N_TERMS SHALL transition to DONE; out_valid rises the cycle after that beat (latency 1).
REQ-021 DONE: out_valid=1, in_ready=0; acc_out and acc_ovf SHALL hold stable while out_ready=0.
REQ-022 DONE with out_ready=1: handshake completes and the FSM returns to IDLE next cycle; acc_out/acc_ovf retain their values until the next start.
REQ-023 start asserted in ACCUM or DONE SHALL be ignored.
REQ-024 acc_out SHALL directly reflect the accumulator register at all times (visible during ACCUM).

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, acc_out=0, acc_ovf=0, count=0, in_ready=0, out_valid=0, busy=0, regardless of clock.
REQ-026 Reset during ACCUM or DONE SHALL discard the partial or pending result; no out_valid SHALL follow.

Structure
REQ-027 State encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the 32-bit product width constant SHALL live in a shared package acc_pkg.
REQ-028 Saturating addition SHALL be a separate sub-module sat_add (inputs acc, operand; outputs sum, sat_event), purely combinational.
REQ-029 The beat counter width SHALL be derived as clog2(N_TERMS+1).

Verification
REQ-030 N_TERMS=4, products 100, -50, 7, 3 with no gaps -> acc_out=60, acc_ovf=0, out_valid high exactly 1 cycle after the 4th beat.
REQ-031 Products 0x7FFF0000 twice, then 0, 0 -> acc_out=0x7FFFFFFF, acc_ovf=1; -0x7FFF0000 twice -> acc_out=0x80000000, acc_ovf=1.
REQ-032 Products 1, 2, 3, 4 with product_ovf=1 on beat 2 -> acc_out=10, acc_ovf=1.
REQ-033 in_valid toggling 1,0,0,1,0,1,1 with values 5 each -> only 4 beats are counted, acc_out=20.
REQ-034 DONE with out_ready=0 for 5 cycles plus start pulses -> out_valid, acc_out and acc_ovf stable, in_ready=0, no restart; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n low after 2 accepted beats -> all outputs 0 asynchronously; new start with 1,1,1,1 -> acc_out=4, acc_ovf=0.
